deser_frame_sequencer: RTL and testbench
========================================

# deser_frame_sequencer

Controller that sequences the serial word deserializer for whole frames. It arms the deserializer with a one-cycle start pulse and captures each completed word on the word-complete strobe (RCO) into an internal word FIFO. It checks that each frame delivers the expected word count and presents words downstream on a valid/ready interface. It sits between the deserializer instance and the frame consumer logic.

## Interface
- WORD_SIZE, 8, width of deserializer word and of word_data
- FRAME_WORDS, 2, words per frame (serial frame length / WORD_SIZE); ≥1
- FIFO_DEPTH, 4, word FIFO entries; power of two, ≥ FRAME_WORDS
- TIMEOUT_CYCLES, 1024, watchdog limit (used only with the Configuration macro)
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high
- enable  input  1  level; permits starting new frames
- deser_busy  input  1  deserializer busy
- deser_rco  input  1  deserializer word-complete strobe, one cycle per word
- deser_data  input  WORD_SIZE  deserializer word, valid while deser_rco=1
- deser_start  output  1  one-cycle start pulse to deserializer
- word_data  output  WORD_SIZE  FIFO head word
- word_valid  output  1  FIFO not empty
- word_ready  input  1  consumer accepts head word
- frame_done  output  1  one-cycle pulse, frame received with correct word count
- short_frame  output  1  one-cycle pulse, deserializer went idle with fewer than FRAME_WORDS words
- frame_count  output  16  count of good frames, wraps 0xFFFF→0

## Operation
- FSM states: IDLE, START, RECV, DONE.
- IDLE: go to START when enable=1, deser_busy=0, and FIFO free entries ≥ FRAME_WORDS. Otherwise stay in IDLE.
- START: deser_start=1 for this cycle only. Clear the word counter. Go to RECV unconditionally.
- RECV: each cycle with deser_rco=1 pushes deser_data and increments the word counter (saturating at FRAME_WORDS).
  - Leave RECV on the first cycle with deser_busy=0.
  - word counter = FRAME_WORDS → DONE.
  - Otherwise pulse short_frame and go to IDLE.
  - deser_rco is honoured in that same exit cycle.
- Extra words beyond FRAME_WORDS are discarded, not pushed. The frame still counts as good.
- DONE: pulse frame_done, increment frame_count, go to IDLE.
- FIFO: push as above; pop when word_valid & word_ready. Simultaneous push/pop is legal in any occupancy.
  - Overflow cannot occur, because of the free-space gating in IDLE.
  - Pop when empty is ignored.
- enable deasserted during START/RECV/DONE does not abort the frame; it only blocks the next start.

## Timing
- Reset values:
  - state=IDLE; deser_start=0, frame_done=0, short_frame=0, frame_count=0.
  - FIFO empty, so word_valid=0 and word_data=0.
- deser_start is registered and asserts the cycle after the start condition is met in IDLE.
- Push latency: a word captured on the deser_rco cycle is visible as word_valid/word_data on the next cycle.
- frame_done is asserted the cycle after RECV exits.
- Minimum turnaround is 4 cycles from one deser_start pulse to the earliest next one, with the path IDLE→START→RECV(≥1)→DONE→IDLE.
- The reset value of every output holds while reset is high. Reset asserted mid-frame discards FIFO contents and counters. The deserializer is reset by the same signal.

## Configuration
- DESER_FRAME_SEQ_TIMEOUT_EN defined:
  - Adds a watchdog counter, cleared on entry to RECV and on every deser_rco.
  - When it reaches TIMEOUT_CYCLES in RECV: pulse output timeout (1 bit, reset 0) and output deser_clear (1 bit, reset 0) for one cycle, then return to IDLE without frame_done.
  - Already-pushed words remain in the FIFO.
- Not defined: no watchdog, no timeout/deser_clear ports. RECV waits indefinitely for deser_busy=0.

## Structure
- Shared package deser_frame_seq_pkg: FSM state enum (IDLE, START, RECV, DONE), frame_count width constant (16), clog2 function.
- Sub-module deser_word_fifo: synchronous FIFO with parameters WORD_SIZE and FIFO_DEPTH.
  - Ports: push, push_data, pop, head_data, empty, free_count.
  - Pointers use clog2(FIFO_DEPTH)+1 bits for full/empty discrimination.

## Test plan
- Nominal frame (WORD_SIZE=8, FRAME_WORDS=2): enable=1, model deserializer emits 0xA5 then 0x3C → deser_start pulses once; frame_done once; frame_count=1; word_data reads 0xA5 then 0x3C.
- Short frame: model emits only one RCO (0x55) then drops busy → short_frame pulses; frame_count stays 0; one word 0x55 in FIFO.
- Backpressure: word_ready=0, FIFO_DEPTH=4, three frames requested → two frames received, no third deser_start until the consumer pops ≥2 words; no data lost.
- Simultaneous push/pop: FIFO at 3 entries, RCO and word_ready=1 in the same cycle → occupancy stays 3; order preserved.
- Reset mid-RECV after one word → all outputs at reset values the next cycle; word_valid=0; FSM restarts cleanly with enable=1.
- With DESER_FRAME_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, busy held high with no RCO → timeout and deser_clear pulse 16 cycles after RECV entry; FSM returns to IDLE.

Source files
------------

// File: rtl/deser_frame_seq_pkg.sv
// Shared types and helpers for the deserializer frame sequencer.
// Holds the FSM state encoding, the frame counter width and a width helper.
package deser_frame_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RECV  = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam int FRAME_COUNT_W = 16;

    // Bits needed to index 'value' entries; 1 for value <= 2.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return (result == 0) ? 1 : result;
    endfunction

endpackage

// File: rtl/deser_word_fifo.sv
// Word FIFO: push visible at the head one cycle later; pop of an empty FIFO is ignored.
// Pushes are refused only when full with no pop that cycle; the sequencer's free-space gating avoids that.
module deser_word_fifo
    import deser_frame_seq_pkg::*;
#(
    parameter int WORD_SIZE  = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int AW = clog2(FIFO_DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 push,
    input  logic [WORD_SIZE-1:0] push_data,
    input  logic                 pop,
    output logic [WORD_SIZE-1:0] head_data,
    output logic                 empty,
    output logic [AW:0]          free_count
);

    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    logic [WORD_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]          rd_ptr_q, rd_ptr_d;
    logic [AW:0]          used;
    logic                 full;
    logic                 do_push;
    logic                 do_pop;

    // Pointers carry one extra wrap bit so full and empty stay distinct.
    always_comb begin
        used       = wr_ptr_q - rd_ptr_q;
        empty      = (used == '0);
        full       = (used == DEPTH_C);
        free_count = DEPTH_C - used;
        do_pop     = pop && !empty;
        do_push    = push && (!full || do_pop);
        wr_ptr_d   = do_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d   = do_pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        head_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/deser_frame_sequencer.sv
// Frame sequencer: registered start/done/short pulses, words visible one cycle after RCO.
// New frames start only with FRAME_WORDS free FIFO entries; DESER_FRAME_SEQ_TIMEOUT_EN adds a RECV watchdog.
module deser_frame_sequencer
    import deser_frame_seq_pkg::*;
#(
    parameter int WORD_SIZE      = 8,
    parameter int FRAME_WORDS    = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     deser_busy,
    input  logic                     deser_rco,
    input  logic [WORD_SIZE-1:0]     deser_data,
    output logic                     deser_start,
    output logic [WORD_SIZE-1:0]     word_data,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic                     frame_done,
    output logic                     short_frame,
    output logic [FRAME_COUNT_W-1:0] frame_count
`ifdef DESER_FRAME_SEQ_TIMEOUT_EN
    ,
    output logic                     timeout,
    output logic                     deser_clear
`endif
);

    localparam int AW    = clog2(FIFO_DEPTH);
    localparam int CNT_W = clog2(FRAME_WORDS + 1);
    localparam logic [AW:0]          FREE_NEED = (AW + 1)'(FRAME_WORDS);
    localparam logic [CNT_W-1:0]     CNT_FULL  = CNT_W'(FRAME_WORDS);
    localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
    localparam logic [FRAME_COUNT_W-1:0] FC_ONE = FRAME_COUNT_W'(1);

    if (FIFO_DEPTH < FRAME_WORDS || FRAME_WORDS < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("deser_frame_sequencer: invalid FRAME_WORDS/FIFO_DEPTH/TIMEOUT_CYCLES");
    end

    seq_state_t               state_q, state_d;
    logic [CNT_W-1:0]         word_cnt_q, word_cnt_d;
    logic                     deser_start_q, deser_start_d;
    logic                     frame_done_q, frame_done_d;
    logic                     short_frame_q, short_frame_d;
    logic [FRAME_COUNT_W-1:0] frame_count_q, frame_count_d;
    logic                     push;
    logic                     fifo_empty;
    logic [AW:0]              free_count;

`ifdef DESER_FRAME_SEQ_TIMEOUT_EN
    localparam int WD_W = clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_ONE   = WD_W'(1);

    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            timeout_q, timeout_d;
    logic            deser_clear_q, deser_clear_d;
`endif

    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        deser_start_d = 1'b0;
        frame_done_d  = 1'b0;
        short_frame_d = 1'b0;
        frame_count_d = frame_count_q;
        push          = 1'b0;
`ifdef DESER_FRAME_SEQ_TIMEOUT_EN
        wdog_d        = wdog_q;
        timeout_d     = 1'b0;
        deser_clear_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (enable && !deser_busy && (free_count >= FREE_NEED)) begin
                    state_d       = START;
                    deser_start_d = 1'b1;
                end
            end
            START: begin
                word_cnt_d = '0;
                state_d    = RECV;
`ifdef DESER_FRAME_SEQ_TIMEOUT_EN
                wdog_d     = '0;
`endif
            end
            RECV: begin
                // Words past the frame length are dropped but still leave the frame good.
                if (deser_rco && (word_cnt_q != CNT_FULL)) begin
                    push       = 1'b1;
                    word_cnt_d = word_cnt_q + CNT_ONE;
                end
`ifdef DESER_FRAME_SEQ_TIMEOUT_EN
                wdog_d = deser_rco ? '0 : (wdog_q + WD_ONE);
`endif
                if (!deser_busy) begin
                    if (word_cnt_d == CNT_FULL) begin
                        state_d       = DONE;
                        frame_done_d  = 1'b1;
                        frame_count_d = frame_count_q + FC_ONE;
                    end else begin
                        state_d       = IDLE;
                        short_frame_d = 1'b1;
                    end
                end
`ifdef DESER_FRAME_SEQ_TIMEOUT_EN
                else if (!deser_rco && (wdog_q == WD_LIMIT)) begin
                    state_d       = IDLE;
                    timeout_d     = 1'b1;
                    deser_clear_d = 1'b1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            word_cnt_q    <= '0;
            deser_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            short_frame_q <= 1'b0;
            frame_count_q <= '0;
`ifdef DESER_FRAME_SEQ_TIMEOUT_EN
            wdog_q        <= '0;
            timeout_q     <= 1'b0;
            deser_clear_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            word_cnt_q    <= word_cnt_d;
            deser_start_q <= deser_start_d;
            frame_done_q  <= frame_done_d;
            short_frame_q <= short_frame_d;
            frame_count_q <= frame_count_d;
`ifdef DESER_FRAME_SEQ_TIMEOUT_EN
            wdog_q        <= wdog_d;
            timeout_q     <= timeout_d;
            deser_clear_q <= deser_clear_d;
`endif
        end
    end

    deser_word_fifo #(
        .WORD_SIZE  (WORD_SIZE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_data  (deser_data),
        .pop        (word_ready),
        .head_data  (word_data),
        .empty      (fifo_empty),
        .free_count (free_count)
    );

    assign word_valid  = !fifo_empty;
    assign deser_start = deser_start_q;
    assign frame_done  = frame_done_q;
    assign short_frame = short_frame_q;
    assign frame_count = frame_count_q;
`ifdef DESER_FRAME_SEQ_TIMEOUT_EN
    assign timeout     = timeout_q;
    assign deser_clear = deser_clear_q;
`endif

endmodule

// File: tb/tb_deser_frame_sequencer.sv
// Directed bench for deser_frame_sequencer: cycle table for a nominal frame, then
// hand sequences for short frame, backpressure, simultaneous push/pop and mid-frame reset.
module tb_deser_frame_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        deser_busy;
    logic        deser_rco;
    logic [7:0]  deser_data;
    logic        deser_start;
    logic [7:0]  word_data;
    logic        word_valid;
    logic        word_ready;
    logic        frame_done;
    logic        short_frame;
    logic [15:0] frame_count;

    deser_frame_sequencer #(
        .WORD_SIZE      (8),
        .FRAME_WORDS    (2),
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .deser_busy  (deser_busy),
        .deser_rco   (deser_rco),
        .deser_data  (deser_data),
        .deser_start (deser_start),
        .word_data   (word_data),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .frame_done  (frame_done),
        .short_frame (short_frame),
        .frame_count (frame_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] exp_fc = 16'd0;

    typedef struct {
        logic       en, busy, rco;
        logic [7:0] data;
        logic       rdy;
        logic       x_start, x_valid;
        logic [7:0] x_data;
        logic       x_done, x_short;
        logic [15:0] x_fc;
    } vec_t;

    vec_t vecs[9];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs at a falling edge and advance to the next falling edge.
    task automatic drive(input logic en, input logic busy, input logic rco,
                         input logic [7:0] d, input logic rdy);
        enable     = en;
        deser_busy = busy;
        deser_rco  = rco;
        deser_data = d;
        word_ready = rdy;
        @(negedge clock);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk1({tag, "_start"}, deser_start, 1'b0);
        chk1({tag, "_valid"}, word_valid, 1'b0);
        chk8({tag, "_data"}, word_data, 8'h00);
        chk1({tag, "_done"}, frame_done, 1'b0);
        chk1({tag, "_short"}, short_frame, 1'b0);
        chk16({tag, "_fc"}, frame_count, 16'd0);
    endtask

    task automatic wait_start(input int budget, input logic rdy, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (deser_start) begin
                seen = 1'b1;
                break;
            end
            drive(1'b1, 1'b0, 1'b0, 8'h00, rdy);
        end
    endtask

    // Called in the START cycle; returns in the DONE cycle.
    task automatic do_frame(input logic [7:0] d0, input logic [7:0] d1,
                            input logic r0, input logic r1);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        if (r0 && word_valid) begin
            chk8("frame_pop0", word_data, exp_q[0]);
            void'(exp_q.pop_front());
        end
        exp_q.push_back(d0);
        drive(1'b1, 1'b1, 1'b1, d0, r0);
        if (r1 && word_valid) begin
            chk8("frame_pop1", word_data, exp_q[0]);
            void'(exp_q.pop_front());
        end
        exp_q.push_back(d1);
        drive(1'b1, 1'b1, 1'b1, d1, r1);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        exp_fc++;
        chk1("frame_done", frame_done, 1'b1);
        chk16("frame_count", frame_count, exp_fc);
    endtask

    task automatic pop_check(input logic en);
        chk1("pop_valid", word_valid, 1'b1);
        if (exp_q.size() > 0) begin
            chk8("pop_data", word_data, exp_q[0]);
            void'(exp_q.pop_front());
        end
        drive(en, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic drain_all();
        while (exp_q.size() > 0) begin
            pop_check(1'b0);
        end
        chk1("drain_empty", word_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        //             en   busy rco  data   rdy  start valid data   done short fc
        vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 16'd0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 16'd0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 16'd1};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 16'd1};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd1};

        reset      = 1'b1;
        enable     = 1'b0;
        deser_busy = 1'b0;
        deser_rco  = 1'b0;
        deser_data = 8'h00;
        word_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;

        // Nominal frame A5, 3C, then drained.
        foreach (vecs[i]) begin
            chk1($sformatf("vec%0d_start", i), deser_start, vecs[i].x_start);
            chk1($sformatf("vec%0d_valid", i), word_valid, vecs[i].x_valid);
            chk8($sformatf("vec%0d_data", i), word_data, vecs[i].x_data);
            chk1($sformatf("vec%0d_done", i), frame_done, vecs[i].x_done);
            chk1($sformatf("vec%0d_short", i), short_frame, vecs[i].x_short);
            chk16($sformatf("vec%0d_fc", i), frame_count, vecs[i].x_fc);
            drive(vecs[i].en, vecs[i].busy, vecs[i].rco, vecs[i].data, vecs[i].rdy);
        end
        exp_fc = 16'd1;

        // Short frame: one word then busy drops.
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk1("short_start", deser_start, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 8'h55, 1'b0);
        chk1("short_word_valid", word_valid, 1'b1);
        chk8("short_word_data", word_data, 8'h55);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk1("short_pulse", short_frame, 1'b1);
        chk1("short_no_done", frame_done, 1'b0);
        chk16("short_fc", frame_count, exp_fc);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk1("short_pulse_end", short_frame, 1'b0);
        exp_q.push_back(8'h55);
        drain_all();

        // Backpressure: two frames fill the FIFO, the third waits for two pops.
        wait_start(8, 1'b0, seen);
        chk1("bp_start1", seen, 1'b1);
        do_frame(8'h11, 8'h22, 1'b0, 1'b0);
        wait_start(8, 1'b0, seen);
        chk1("bp_start2", seen, 1'b1);
        do_frame(8'h33, 8'h44, 1'b0, 1'b0);
        wait_start(10, 1'b0, seen);
        chk1("bp_no_third_start", seen, 1'b0);
        pop_check(1'b1);
        chk1("bp_one_pop_no_start", deser_start, 1'b0);
        pop_check(1'b1);
        wait_start(6, 1'b0, seen);
        chk1("bp_start3", seen, 1'b1);
        do_frame(8'h55, 8'h66, 1'b0, 1'b0);
        chk16("bp_fifo_words", 16'(exp_q.size()), 16'd4);
        drain_all();

        // Push and pop in the same cycle at three entries.
        wait_start(8, 1'b0, seen);
        chk1("pp_start1", seen, 1'b1);
        do_frame(8'hA1, 8'hA2, 1'b0, 1'b0);
        wait_start(8, 1'b0, seen);
        chk1("pp_start2", seen, 1'b1);
        do_frame(8'hB1, 8'hB2, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        drain_all();

        // Reset after one word of a frame.
        wait_start(8, 1'b0, seen);
        chk1("rst_start", seen, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 8'h77, 1'b0);
        chk1("rst_word_pushed", word_valid, 1'b1);
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        exp_q.delete();
        exp_fc = 16'd0;
        drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        check_reset_outputs("rst_held");
        reset = 1'b0;

        // Restart: extra word in the exit cycle is dropped; next frame ends with RCO on exit.
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        wait_start(4, 1'b0, seen);
        chk1("restart_start", seen, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 8'h81, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 8'h82, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 8'h83, 1'b0);
        chk1("extra_done", frame_done, 1'b1);
        chk16("extra_fc", frame_count, 16'd1);
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h82);
        wait_start(6, 1'b0, seen);
        chk1("exitrco_start", seen, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 8'h91, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 8'h92, 1'b0);
        chk1("exitrco_done", frame_done, 1'b1);
        chk1("exitrco_no_short", short_frame, 1'b0);
        chk16("exitrco_fc", frame_count, 16'd2);
        exp_q.push_back(8'h91);
        exp_q.push_back(8'h92);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        drain_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
